// File: rtl/bcd_time_counter.sv
// BCD time-of-day counter (HH:MM:SS.mmm, 24 h) advanced by a prescaled 1 ms tick.
// A load strobe copies a validated time into the counter and restarts the prescaler.
module bcd_time_counter #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        load,
    input  logic [7:0]  hours_i,
    input  logic [7:0]  minutes_i,
    input  logic [7:0]  seconds_i,
    input  logic [11:0] milli_i,
    output logic [7:0]  hours_o,
    output logic [7:0]  minutes_o,
    output logic [7:0]  seconds_o,
    output logic [11:0] milli_o,
    output logic        ms_tick,
    output logic        sec_tick,
    output logic        day_wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(DIV - 1);

    logic [PW-1:0] presc;
    logic          advance;

    logic [11:0] milli_n;
    logic [7:0]  seconds_n;
    logic [7:0]  minutes_n;
    logic [7:0]  hours_n;
    logic        milli_wrap;
    logic        sec_wrap;
    logic        min_wrap;
    logic        hour_wrap;

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [11:0] milli_inc(input logic [11:0] x);
        logic [3:0] d0, d1, d2;
        d0 = digit_inc(x[3:0]);
        d1 = (x[3:0] == 4'd9) ? digit_inc(x[7:4]) : x[7:4];
        d2 = (x[7:0] == 8'h99) ? digit_inc(x[11:8]) : x[11:8];
        return {d2, d1, d0};
    endfunction

    function automatic logic [7:0] sixty_inc(input logic [7:0] x);
        if (x[3:0] != 4'd9) begin
            return {x[7:4], x[3:0] + 4'd1};
        end
        return (x[7:4] == 4'd5) ? 8'h00 : {x[7:4] + 4'd1, 4'd0};
    endfunction

    function automatic logic [7:0] hours_inc(input logic [7:0] x);
        if (x == 8'h23) begin
            return 8'h00;
        end
        return (x[3:0] == 4'd9) ? {x[7:4] + 4'd1, 4'd0} : {x[7:4], x[3:0] + 4'd1};
    endfunction

    function automatic logic valid_pair(input logic [7:0] x, input logic [7:0] max_val);
        return (x[3:0] <= 4'd9) && (x[7:4] <= 4'd9) && (x <= max_val);
    endfunction

    function automatic logic valid_milli(input logic [11:0] x);
        return (x[3:0] <= 4'd9) && (x[7:4] <= 4'd9) && (x[11:8] <= 4'd9);
    endfunction

    assign advance = run && !load && (presc == PRESC_TC);

    // Carry ripples through every field within the single advance edge.
    always_comb begin
        milli_wrap = (milli_o == 12'h999);
        sec_wrap   = milli_wrap && (seconds_o == 8'h59);
        min_wrap   = sec_wrap && (minutes_o == 8'h59);
        hour_wrap  = min_wrap && (hours_o == 8'h23);
        milli_n    = milli_inc(milli_o);
        seconds_n  = milli_wrap ? sixty_inc(seconds_o) : seconds_o;
        minutes_n  = sec_wrap ? sixty_inc(minutes_o) : minutes_o;
        hours_n    = min_wrap ? hours_inc(hours_o) : hours_o;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (load) begin
            presc <= '0;
        end else if (run) begin
            presc <= (presc == PRESC_TC) ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hours_o   <= 8'h00;
            minutes_o <= 8'h00;
            seconds_o <= 8'h00;
            milli_o   <= 12'h000;
        end else if (load) begin
            hours_o   <= valid_pair(hours_i, 8'h23)   ? hours_i   : 8'h00;
            minutes_o <= valid_pair(minutes_i, 8'h59) ? minutes_i : 8'h00;
            seconds_o <= valid_pair(seconds_i, 8'h59) ? seconds_i : 8'h00;
            milli_o   <= valid_milli(milli_i)         ? milli_i   : 12'h000;
        end else if (advance) begin
            hours_o   <= hours_n;
            minutes_o <= minutes_n;
            seconds_o <= seconds_n;
            milli_o   <= milli_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_tick  <= 1'b0;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
        end else begin
            ms_tick  <= advance;
            sec_tick <= advance && milli_wrap;
            day_wrap <= advance && hour_wrap;
        end
    end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter with DIV = 10 (CLK_HZ=10, TICK_HZ=1).
module tb_bcd_time_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        load;
    logic [7:0]  hours_i;
    logic [7:0]  minutes_i;
    logic [7:0]  seconds_i;
    logic [11:0] milli_i;
    logic [7:0]  hours_o;
    logic [7:0]  minutes_o;
    logic [7:0]  seconds_o;
    logic [11:0] milli_o;
    logic        ms_tick;
    logic        sec_tick;
    logic        day_wrap;

    int n_checks = 0;
    int n_pass   = 0;

    logic [35:0] tv;
    logic [2:0]  pv;
    assign tv = {hours_o, minutes_o, seconds_o, milli_o};
    assign pv = {ms_tick, sec_tick, day_wrap};

    bcd_time_counter #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .load      (load),
        .hours_i   (hours_i),
        .minutes_i (minutes_i),
        .seconds_i (seconds_i),
        .milli_i   (milli_i),
        .hours_o   (hours_o),
        .minutes_o (minutes_o),
        .seconds_o (seconds_o),
        .milli_o   (milli_o),
        .ms_tick   (ms_tick),
        .sec_tick  (sec_tick),
        .day_wrap  (day_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s, input logic [11:0] ms);
        hours_i   = h;
        minutes_i = m;
        seconds_i = s;
        milli_i   = ms;
        load      = 1'b1;
        step(1);
        load      = 1'b0;
    endtask

    int ticks;

    initial begin
        reset = 1'b1; run = 1'b0; load = 1'b0;
        hours_i = 8'h00; minutes_i = 8'h00; seconds_i = 8'h00; milli_i = 12'h000;
        step(2);
        reset = 1'b0;
        run   = 1'b1;

        // 1: reset state and first advance after DIV cycles
        chk("reset_time", tv, 36'h00_00_00_000);
        chk("reset_pulses", {33'd0, pv}, 36'd0);
        step(9);
        chk("t1_pre_tick", {tv[11:0], 21'd0, pv}, 36'd0);
        step(1);
        chk("t1_first_ms", tv, 36'h00_00_00_001);
        chk("t1_tick", {33'd0, pv}, 36'b100);
        step(1);
        chk("t1_tick_once", {33'd0, pv}, 36'd0);

        // 2: seconds carry into minutes
        do_load(8'h00, 8'h00, 8'h59, 12'h999);
        chk("t2_loaded", tv, 36'h00_00_59_999);
        step(10);
        chk("t2_time", tv, 36'h00_01_00_000);
        chk("t2_pulses", {33'd0, pv}, 36'b110);

        // 3: day wrap
        do_load(8'h23, 8'h59, 8'h59, 12'h999);
        step(10);
        chk("t3_time", tv, 36'h00_00_00_000);
        chk("t3_pulses", {33'd0, pv}, 36'b111);
        step(1);
        chk("t3_pulses_end", {33'd0, pv}, 36'd0);

        // hours digit carry without day wrap
        do_load(8'h19, 8'h59, 8'h59, 12'h999);
        step(10);
        chk("hr_carry_time", tv, 36'h20_00_00_000);
        chk("hr_carry_pulses", {33'd0, pv}, 36'b110);

        // 4: per-field validation
        do_load(8'h24, 8'h5A, 8'h30, 12'h123);
        chk("t4_validate", tv, 36'h00_00_30_123);
        do_load(8'h19, 8'h60, 8'h0F, 12'h9A9);
        chk("t4_validate_b", tv, 36'h19_00_00_000);

        // 5: run pause keeps the prescaler phase
        run = 1'b0;
        do_load(8'h00, 8'h00, 8'h00, 12'h000);
        chk("t5_load_while_stopped", tv, 36'h00_00_00_000);
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            run = (i < 5 || i >= 25);
            step(1);
            if (ms_tick) ticks++;
        end
        chk("t5_tick_count", 36'(ticks), 36'd1);
        chk("t5_tick_on_10th", {33'd0, pv}, 36'b100);
        chk("t5_time", tv, 36'h00_00_00_001);

        // 6: load wins over an advance on the same edge
        run = 1'b1;
        do_load(8'h00, 8'h00, 8'h00, 12'h000);
        step(9);
        do_load(8'h12, 8'h34, 8'h56, 12'h789);
        chk("t6_loaded", tv, 36'h12_34_56_789);
        chk("t6_no_tick", {33'd0, pv}, 36'd0);
        step(9);
        chk("t6_pre_tick", {33'd0, pv}, 36'd0);
        step(1);
        chk("t6_time", tv, 36'h12_34_56_790);
        chk("t6_tick", {33'd0, pv}, 36'b100);

        // load held several cycles follows inputs and pins the prescaler
        hours_i = 8'h01; minutes_i = 8'h02; seconds_i = 8'h03; milli_i = 12'h004;
        load = 1'b1;
        step(1);
        hours_i = 8'h05; minutes_i = 8'h06; seconds_i = 8'h07; milli_i = 12'h099;
        step(12);
        chk("hold_load_time", tv, 36'h05_06_07_099);
        chk("hold_load_no_tick", {33'd0, pv}, 36'd0);
        load = 1'b0;
        step(10);
        chk("hold_load_adv", tv, 36'h05_06_07_100);

        // reset mid-count restarts the prescaler
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_reset_time", tv, 36'h00_00_00_000);
        step(9);
        chk("mid_reset_pre", {33'd0, pv}, 36'd0);
        step(1);
        chk("mid_reset_adv", tv, 36'h00_00_00_001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
